// File: rtl/alu_arb_seq.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (drive ALU) -> RESP (hold result).
module alu_arb_seq #(
  parameter int WIDTH      = 16,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_mode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_mode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_data,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_data,
  input  logic             resp1_ready,
  output logic [3:0]       ALU_mode,
  output logic             ALU_en,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam int         NREQ     = 2;
  localparam logic [3:0] MODE_NOP = 4'd8;
  localparam logic [3:0] MODE_RSV = 4'd15;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  op_t [NREQ-1:0]             req_op;
  logic [NREQ-1:0]            req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ-1:0][WIDTH-1:0] resp_data;

  state_t           state, state_nx;
  op_t              op_q;
  logic [WIDTH-1:0] result;
  logic             ptr, owner, gnt, accept, op_nop;

  assign req_op[0]  = {req0_mode, req0_a, req0_b};
  assign req_op[1]  = {req1_mode, req1_a, req1_b};
  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_data  = resp_data[0];
  assign resp1_data  = resp_data[1];

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = ptr;
    if (req_valid == 2'b01)      gnt = 1'b0;
    else if (req_valid == 2'b10) gnt = 1'b1;
  end

  assign accept = rst_n && (state == IDLE) && req_valid[gnt];
  assign op_nop = (op_q.mode == MODE_NOP) || (op_q.mode == MODE_RSV);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= FIRST_PRIO;
      owner     <= 1'b0;
      result    <= '0;
      op_q.mode <= MODE_NOP;
      op_q.a    <= '0;
      op_q.b    <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op[gnt];
        owner <= gnt;
      end
      if (state == EXEC) result <= op_nop ? '0 : alu_out;
      if (state == RESP && resp_ready[owner]) ptr <= ~owner;
    end
  end

  // Outputs sit at their idle values whenever reset is asserted.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    ALU_en     = 1'b0;
    ALU_mode   = MODE_NOP;
    alu_a      = '0;
    alu_b      = '0;
    busy       = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          req_ready[gnt] = req_valid[gnt];
          if (accept) state_nx = EXEC;
        end
        EXEC: begin
          busy  = 1'b1;
          alu_a = op_q.a;
          alu_b = op_q.b;
          if (!op_nop) begin
            ALU_en   = 1'b1;
            ALU_mode = op_q.mode;
          end
          state_nx = RESP;
        end
        RESP: begin
          busy              = 1'b1;
          resp_valid[owner] = 1'b1;
          resp_data[owner]  = result;
          if (resp_ready[owner]) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb_seq.sv
// Bench for alu_arb_seq: vector table plus arbitration, back-pressure, reset and back-to-back sequences.
module tb_alu_arb_seq;

  typedef struct {
    int          id;
    logic [3:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_mode, req1_mode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [15:0] resp0_data, resp1_data;
  logic [3:0]  ALU_mode;
  logic        ALU_en, busy;
  logic [15:0] alu_a, alu_b, alu_out;

  logic [1:0]  rq_v = 2'b00;
  logic [1:0]  rs_rdy = 2'b11;
  logic [3:0]  rq_mode [2];
  logic [15:0] rq_a [2];
  logic [15:0] rq_b [2];
  logic [1:0]  rq_rdy, rs_v;
  logic [15:0] rs_d [2];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  sb_t  sb [$];
  vec_t vt [9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req0_valid  = rq_v[0];
  assign req1_valid  = rq_v[1];
  assign req0_mode   = rq_mode[0];
  assign req1_mode   = rq_mode[1];
  assign req0_a      = rq_a[0];
  assign req0_b      = rq_b[0];
  assign req1_a      = rq_a[1];
  assign req1_b      = rq_b[1];
  assign resp0_ready = rs_rdy[0];
  assign resp1_ready = rs_rdy[1];

  always_comb begin
    rq_rdy  = {req1_ready, req0_ready};
    rs_v    = {resp1_valid, resp0_valid};
    rs_d[0] = resp0_data;
    rs_d[1] = resp1_data;
  end

  // Stand-in for the external ALU; garbage while disabled so a leaked capture shows up.
  function automatic logic [15:0] tb_alu(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << 1;
      4'd7:    return a >> 1;
      4'd9:    return ~(a & b);
      4'd10:   return ~(a | b);
      4'd11:   return ~(a ^ b);
      4'd12:   return a + 16'd1;
      4'd13:   return a - 16'd1;
      4'd14:   return b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_out = ALU_en ? tb_alu(ALU_mode, alu_a, alu_b) : 16'hDEAD;

  alu_arb_seq #(.WIDTH(16), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .ALU_mode(ALU_mode), .ALU_en(ALU_en), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where some ready is seen (g = ready vector), bounded.
  task automatic wait_any(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rq_rdy != 2'b00) begin
        g = rq_rdy;
        return;
      end
      step();
    end
    n_cmp++;
    n_err++;
    $display("FAIL grant_timeout: no ready within 20 cycles, expected a grant");
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      step();
      if (sb.size() == 0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
  endtask

  task automatic run_op(input vec_t v);
    logic [1:0] g;
    logic       nop;
    int         id;
    id  = v.id;
    nop = (v.mode == 4'd8) || (v.mode == 4'd15);
    rs_rdy      = 2'b11;
    rq_mode[id] = v.mode;
    rq_a[id]    = v.a;
    rq_b[id]    = v.b;
    rq_v[id]    = 1'b1;
    wait_any(g);
    chk("op_grant", 32'(g), 32'(1 << id));
    chk("idle_busy", 32'(busy), 32'd0);
    sb.push_back('{id, v.exp});
    step();
    rq_v[id] = 1'b0;
    @(negedge clk);
    chk("exec_en", 32'(ALU_en), 32'(!nop));
    chk("exec_mode", 32'(ALU_mode), nop ? 32'd8 : 32'(v.mode));
    chk("exec_a", 32'(alu_a), 32'(v.a));
    chk("exec_b", 32'(alu_b), 32'(v.b));
    chk("exec_ready", 32'(rq_rdy), 32'd0);
    step();
    @(negedge clk);
    chk("resp_valid", 32'(rs_v), 32'(1 << id));
    chk("resp_data", 32'(rs_d[id]), 32'(v.exp));
    chk("resp_other_data", 32'(rs_d[1 - id]), 32'd0);
    step();
  endtask

  // Scoreboard: every response handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (rs_v == 2'b11) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_both: both resp_valid high, expected at most one");
      end
      for (int i = 0; i < 2; i++) begin
        if (rs_v[i] && rs_rdy[i]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_unexpected: requester %0d answered with 0x%0h, expected no response", i, rs_d[i]);
          end else begin
            e = sb.pop_front();
            chk("sb_owner", 32'(i), 32'(e.id));
            chk("sb_data", 32'(rs_d[i]), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] g;
    int         t_prev;

    vt[0] = '{0, 4'd0,  16'h0003, 16'h0004, 16'h0007};
    vt[1] = '{0, 4'd1,  16'h0010, 16'h0003, 16'h000D};
    vt[2] = '{1, 4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0};
    vt[3] = '{1, 4'd4,  16'hAAAA, 16'hFFFF, 16'h5555};
    vt[4] = '{0, 4'd0,  16'hFFFF, 16'h0001, 16'h0000};
    vt[5] = '{1, 4'd15, 16'h1234, 16'h5678, 16'h0000};
    vt[6] = '{0, 4'd8,  16'h0005, 16'h0005, 16'h0000};
    vt[7] = '{1, 4'd3,  16'h00F0, 16'h0F00, 16'h0FF0};
    vt[8] = '{0, 4'd14, 16'h1111, 16'hBEEF, 16'hBEEF};

    // Reset with both requesters already valid
    rq_mode[0] = 4'd0; rq_a[0] = 16'h0001; rq_b[0] = 16'h0001;
    rq_mode[1] = 4'd0; rq_a[1] = 16'h0002; rq_b[1] = 16'h0002;
    rq_v = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rq_rdy), 32'd0);
    chk("rst_resp_valid", 32'(rs_v), 32'd0);
    chk("rst_resp0_data", 32'(rs_d[0]), 32'd0);
    chk("rst_resp1_data", 32'(rs_d[1]), 32'd0);
    chk("rst_alu_en", 32'(ALU_en), 32'd0);
    chk("rst_alu_mode", 32'(ALU_mode), 32'd8);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;

    // Round robin with both held valid: 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      wait_any(g);
      chk("arb_grant", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (g[1]) sb.push_back('{1, 16'h0004});
      else      sb.push_back('{0, 16'h0002});
      step();
      if (k == 3) rq_v = 2'b00;
    end
    drain();

    for (int i = 0; i < 9; i++) run_op(vt[i]);

    // Back-pressure on resp0 while req1 waits
    rs_rdy = 2'b10;
    rq_mode[0] = 4'd0; rq_a[0] = 16'h0100; rq_b[0] = 16'h0023;
    rq_v[0] = 1'b1;
    wait_any(g);
    chk("bp_grant0", 32'(g), 32'd1);
    sb.push_back('{0, 16'h0123});
    step();
    rq_v[0] = 1'b0;
    rq_mode[1] = 4'd0; rq_a[1] = 16'h0000; rq_b[1] = 16'h0009;
    rq_v[1] = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(rs_v), 32'd1);
      chk("bp_resp_data", 32'(rs_d[0]), 32'h0123);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      step();
    end
    rs_rdy[0] = 1'b1;
    wait_any(g);
    chk("bp_grant1", 32'(g), 32'd2);
    sb.push_back('{1, 16'h0009});
    step();
    rq_v[1] = 1'b0;
    drain();

    // Leave the pointer at requester 1, then abandon an op in RESP with reset
    run_op(vt[0]);
    rs_rdy = 2'b10;
    rq_mode[0] = 4'd0; rq_a[0] = 16'h0007; rq_b[0] = 16'h0008;
    rq_v[0] = 1'b1;
    wait_any(g);
    chk("rr_grant", 32'(g), 32'd1);
    step();
    rq_v[0] = 1'b0;
    step();
    @(negedge clk);
    chk("rr_in_resp", 32'(rs_v), 32'd1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rr_rst_valid", 32'(rs_v), 32'd0);
    chk("rr_rst_busy", 32'(busy), 32'd0);
    rs_rdy = 2'b11;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_no_resp", 32'(rs_v), 32'd0);
      chk("rr_idle", 32'(busy), 32'd0);
      step();
    end

    // Pointer returned to FIRST_PRIO by reset
    rq_mode[0] = 4'd0; rq_a[0] = 16'h0001; rq_b[0] = 16'h0001;
    rq_mode[1] = 4'd0; rq_a[1] = 16'h0002; rq_b[1] = 16'h0002;
    rq_v = 2'b11;
    wait_any(g);
    chk("rr_ptr_reset", 32'(g), 32'd1);
    if (g[1]) sb.push_back('{1, 16'h0004});
    else      sb.push_back('{0, 16'h0002});
    step();
    rq_v = 2'b00;
    drain();

    // Lone requester 1, back-to-back: one accept every 3 cycles
    rq_mode[1] = 4'd1; rq_a[1] = 16'h0005; rq_b[1] = 16'h0002;
    rq_v[1] = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(g);
      chk("b2b_grant", 32'(g), 32'd2);
      if (k > 0) chk("b2b_gap", 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
      sb.push_back('{1, 16'h0003});
      step();
    end
    rq_v[1] = 1'b0;
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arb_seq.md
ALU_ARB_SEQ -- requirements
Module: alu_arb_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width.
REQ-002 Parameter FIRST_PRIO, default 0, requester favoured first after reset (0 or 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 reqN_mode  input  4  ALU work-mode code (0-14 per ALU control encoding).
REQ-008 reqN_a, reqN_b  input  WIDTH  operands.
REQ-009 respN_valid  output  1  result for requester N is available.
REQ-010 respN_data  output  WIDTH  result for requester N.
REQ-011 respN_ready  input  1  requester N takes the result.
REQ-012 ALU_mode  output  4  mode to ALU control.
REQ-013 ALU_en  output  1  enable to ALU control.
REQ-014 alu_a, alu_b  output  WIDTH  operands to ALU.
REQ-015 alu_out  input  WIDTH  combinational ALU result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-018 IDLE: reqN_ready=1 only for the granted requester, and only when its reqN_valid=1; ALU_en=0; ALU_mode=8; alu_a=alu_b=0.
REQ-019 Grant SHALL be determined as follows: only one requester valid -> that requester; both valid -> requester selected by the round-robin pointer.
REQ-020 On accept (valid&&ready), the block SHALL latch the mode, operands and owner ID, then go to EXEC.
REQ-021 EXEC lasts exactly one cycle: ALU_en=1, ALU_mode=latched mode, alu_a/alu_b=latched operands; alu_out is captured into the result register at the end of that cycle; the next state is RESP.
REQ-022 Latched mode 8 or 15 SHALL still pass through EXEC, with ALU_en=0 and ALU_mode=8; the captured result SHALL be 0.
REQ-023 RESP: respN_valid=1 for the owner only; respN_data=result register; the state SHALL hold until respN_ready=1.
REQ-024 On RESP handshake: go to IDLE; pointer = the requester other than the owner.
REQ-025 In RESP, respN_valid and respN_data SHALL remain stable until the handshake completes.
REQ-026 Latency: accept at cycle T -> EXEC at T+1 -> respN_valid at T+2; with resp ready held high, the block SHALL sustain at most one operation per 3 cycles.
REQ-027 reqN_ready SHALL be 0 in EXEC and RESP; requests held during those states wait and are not lost.
REQ-028 Non-owner respN_valid=0 at all times; both respN_valid never high together.
REQ-029 respN_data of a non-owner SHALL be driven 0.
REQ-030 The pointer SHALL update only on RESP handshake, so a lone requester issuing back-to-back is never blocked.

Reset
REQ-031 rst_n=0 on a clock edge forces: state=IDLE, pointer=FIRST_PRIO, result register=0, latched mode=8, operands=0.
REQ-032 During reset, all outputs SHALL be 0 except ALU_mode=8.
REQ-033 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no response ever issued.
REQ-034 The first accept after rst_n rises SHALL be no earlier than the cycle following the reset release.

Verification
REQ-035 Scenario: req0 mode 0, a=0x0003, b=0x0004 at T -> ALU_en=1 and ALU_mode=0 at T+1; resp0_valid=1 with data 0x0007 at T+2.
REQ-036 Scenario: req0 and req1 valid together after reset (FIRST_PRIO=0) -> req0 granted first; after its response, req1 granted; then req0 again if both remain valid.
REQ-037 Scenario: resp0_ready held 0 for 5 cycles -> resp0_valid/resp0_data stable, req1_ready=0 throughout, busy=1.
REQ-038 Scenario: req1 mode 15 -> EXEC with ALU_en=0 and ALU_mode=8; resp1_data=0x0000.
REQ-039 Scenario: rst_n=0 during RESP -> next cycle IDLE, resp0_valid=0, busy=0; the operation is never answered.
REQ-040 Scenario: req1 alone, mode 1, a=0x0005, b=0x0002, back-to-back -> responses every 3 cycles, and each result matches the ALU model for that mode and operands.
